// File: rtl/carry_select_subtractor16_pipe.sv
// Carry-select subtractor (diff = a - b - bin) with a 2-stage valid/ready pipeline.
// Stage 1 resolves the lower half and both upper-half candidates; stage 2 selects on the mid borrow.
module carry_select_subtractor16_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NBLK = HALF / BLOCK;

    typedef struct packed {
        logic [HALF-1:0] diff_lo;
        logic            borrow_mid;
        logic [HALF-1:0] diff_hi0;
        logic [HALF-1:0] diff_hi1;
        logic            bout0;
        logic            bout1;
        logic            a_msb;
        logic            b_msb;
    } s1_t;

    // Ripple-borrow subtract of one BLOCK-wide slice; returns {borrow_out, diff}.
    function automatic logic [BLOCK:0] block_sub(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             bi);
        logic [BLOCK-1:0] d;
        logic             br;
        d  = '0;
        br = bi;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        return {br, d};
    endfunction

    // Half-width subtract as a chain of BLOCK-wide ripple sub-blocks.
    function automatic logic [HALF:0] half_sub(input logic [HALF-1:0] x,
                                               input logic [HALF-1:0] y,
                                               input logic            bi);
        logic [HALF-1:0] d;
        logic            br;
        d  = '0;
        br = bi;
        for (int unsigned k = 0; k < NBLK; k++) begin
            {br, d[k*BLOCK +: BLOCK]} = block_sub(x[k*BLOCK +: BLOCK], y[k*BLOCK +: BLOCK], br);
        end
        return {br, d};
    endfunction

    s1_t             s1_c;
    s1_t             s1_q;
    logic            s1_valid;
    logic            s2_load;
    logic            in_xfer;
    logic            out_xfer;
    logic [HALF:0]   lo_res;
    logic [HALF:0]   hi0_res;
    logic [HALF:0]   hi1_res;
    logic [HALF-1:0] hi_sel;
    logic [WIDTH-1:0] diff_nxt;
    logic            bout_nxt;
    logic            ovf_nxt;

    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Stage 1: lower half plus both upper-half speculations
    always_comb begin
        lo_res  = half_sub(a[HALF-1:0], b[HALF-1:0], bin);
        hi0_res = half_sub(a[WIDTH-1:HALF], b[WIDTH-1:HALF], 1'b0);
        hi1_res = half_sub(a[WIDTH-1:HALF], b[WIDTH-1:HALF], 1'b1);
        s1_c.diff_lo    = lo_res[HALF-1:0];
        s1_c.borrow_mid = lo_res[HALF];
        s1_c.diff_hi0   = hi0_res[HALF-1:0];
        s1_c.bout0      = hi0_res[HALF];
        s1_c.diff_hi1   = hi1_res[HALF-1:0];
        s1_c.bout1      = hi1_res[HALF];
        s1_c.a_msb      = a[WIDTH-1];
        s1_c.b_msb      = b[WIDTH-1];
    end

    // Stage 2: select the upper half on the actual mid borrow
    always_comb begin
        hi_sel   = s1_q.borrow_mid ? s1_q.diff_hi1 : s1_q.diff_hi0;
        diff_nxt = {hi_sel, s1_q.diff_lo};
        bout_nxt = s1_q.borrow_mid ? s1_q.bout1 : s1_q.bout0;
        ovf_nxt  = (s1_q.a_msb != s1_q.b_msb) && (diff_nxt[WIDTH-1] != s1_q.a_msb);
    end

    // Stage 1 payload; only meaningful while s1_valid is set
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_q <= s1_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            s1_valid  <= in_xfer ? 1'b1 : (s2_load ? 1'b0 : s1_valid);
            out_valid <= s2_load ? 1'b1 : (out_xfer ? 1'b0 : out_valid);
            if (s2_load) begin
                diff <= diff_nxt;
                bout <= bout_nxt;
                ovf  <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_carry_select_subtractor16_pipe.sv
// Bench for carry_select_subtractor16_pipe: directed corner beats, stall, reset flush and random traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_carry_select_subtractor16_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;

    carry_select_subtractor16_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction, borrow = negative result, ovf from sign rule
    function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb, input logic bi);
        exp_t e;
        int   r;
        r    = int'(aa) - int'(bb) - int'(bi);
        e.d  = 16'(r);
        e.bo = (r < 0);
        e.ov = (aa[15] != bb[15]) && (e.d[15] != aa[15]);
        return e;
    endfunction

    // Scoreboard: inputs change only just after posedge, so negedge sees the values of the next edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_vec++;
                n_out++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output diff=%h bout=%b ovf=%b (no beat outstanding)", diff, bout, ovf);
                end else begin
                    e = q.pop_front();
                    if (diff !== e.d || bout !== e.bo || ovf !== e.ov) begin
                        n_err++;
                        $display("FAIL result got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                                 diff, bout, ovf, e.d, e.bo, e.ov);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, bin));
        end
    end

    // Offer one beat and hold it until accepted; returns at posedge+1 after the transfer edge
    task automatic send(input logic [15:0] aa, input logic [15:0] bb, input logic bi);
        int t;
        t = 0;
        a = aa; b = bb; bin = bi; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || diff !== 16'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b diff=%h bout=%b ovf=%b want 0 0000 0 0", out_valid, diff, bout, ovf);
        end
        rst_n = 1'b1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed;
        logic [15:0] ta [7] = '{16'h0000, 16'h8000, 16'h0100, 16'h1234, 16'h7FFF, 16'h0000, 16'h5A5A};
        logic [15:0] tb [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'hFFFF, 16'h0000, 16'h5A5A};
        logic        tbi[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] td [7] = '{16'hFFFF, 16'h7FFF, 16'h00FF, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0000};
        logic        tbo[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        tov[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(ta[i], tb[i], tbi[i]);
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || diff !== td[i] || bout !== tbo[i] || ovf !== tov[i]) begin
                n_err++;
                $display("FAIL directed_%0d got v=%b diff=%h bout=%b ovf=%b want v=1 diff=%h bout=%b ovf=%b",
                         i, out_valid, diff, bout, ovf, td[i], tbo[i], tov[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_stall;
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vbi[4];
        logic [17:0] held;
        int          idx;
        int          outs0;
        idx   = 0;
        outs0 = n_out;
        held  = '0;
        for (int i = 0; i < 4; i++) begin
            va[i]  = 16'($urandom);
            vb[i]  = 16'($urandom);
            vbi[i] = 1'($urandom);
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (idx < 4);
            if (idx < 4) begin
                a = va[idx]; b = vb[idx]; bin = vbi[idx];
            end
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) begin
                n_vec++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_ready_%0d got in_ready=%b out_valid=%b want 0 1", cyc, in_ready, out_valid);
                end
                if (cyc == 2) begin
                    held = {diff, bout, ovf};
                end else begin
                    n_vec++;
                    if ({diff, bout, ovf} !== held) begin
                        n_err++;
                        $display("FAIL stall_hold_%0d got %h want %h", cyc, {diff, bout, ovf}, held);
                    end
                end
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (n_out - outs0 != 4) begin
            n_err++;
            $display("FAIL stall_count got %0d results want 4", n_out - outs0);
        end
    endtask

    task automatic test_reset_inflight;
        int outs0;
        out_ready = 1'b0;
        send(16'h4321, 16'h1111, 1'b0);
        send(16'h0F0F, 16'h00F0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0 || diff !== 16'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush got out_valid=%b diff=%h in_ready=%b want 0 0000 1", out_valid, diff, in_ready);
        end
        outs0     = n_out;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (n_out != outs0) begin
            n_err++;
            $display("FAIL flush_leak got %0d results want 0", n_out - outs0);
        end
    endtask

    task automatic test_random;
        int acc;
        int cyc;
        int outs0;
        acc   = 0;
        cyc   = 0;
        outs0 = n_out;
        while (acc < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(9) < 7);
            a   = 16'($urandom);
            b   = 16'($urandom);
            bin = 1'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (n_out - outs0 != 10000 || q.size() != 0) begin
            n_err++;
            $display("FAIL random_count got %0d results (%0d pending) want 10000 (0 pending)",
                     n_out - outs0, q.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back_stall();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
